// File: rtl/conv_pkg.sv
// Shared types and constants for the convolver column controller.
package conv_pkg;

  localparam int STATE_W = 3;
  localparam int COL_W   = 12;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_K = 3'd1,
    ST_RUN    = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } conv_state_e;

  localparam logic [COL_W-1:0] COL_ZERO   = 12'd0;
  localparam logic [COL_W-1:0] COL_ONE    = 12'd1;
  // Kernel is three columns; the first image result needs three columns in the window.
  localparam logic [COL_W-1:0] K_LAST     = 12'd2;
  localparam logic [COL_W-1:0] FIRST_PROD = 12'd3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_ctrl.sv
// Column-stream controller for a 3x3 convolver: kernel load, strip scan, flush and result drain.
// Optional stall counter port enabled with `define CONV_CTRL_STALL_CNT_EN.
module conv_ctrl
  import conv_pkg::*;
#(
  parameter int BIT_LEN    = 8,
  parameter int CONV_LPOS  = 13,
  parameter int IMG_W      = 16,
  parameter int IMG_STRIPS = 8
) (
  input  logic                   CLK100MHZ,
  input  logic                   i_reset_n,
  input  logic                   i_start,
  input  logic                   i_cmd_kernel,
  input  logic [3*BIT_LEN-1:0]   s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [BIT_LEN-1:0]     o_conv_dato0,
  output logic [BIT_LEN-1:0]     o_conv_dato1,
  output logic [BIT_LEN-1:0]     o_conv_dato2,
  output logic                   o_conv_selecK_I,
  output logic                   o_conv_valid,
  input  logic [CONV_LPOS-1:0]   i_conv_data,
  output logic [CONV_LPOS-1:0]   m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   o_busy,
  output logic                   o_done
`ifdef CONV_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]            o_stall_cnt
`endif
);

  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_FLUSH  = COL_W'(IMG_W);
  localparam logic [COL_W-1:0] STRIP_LAST = COL_W'(IMG_STRIPS - 1);

  conv_state_e            state_q, state_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [COL_W-1:0]       strip_q, strip_d;
  logic                   m_valid_q, m_valid_d;

  logic                   beat_ok_s;
  logic                   s_ready_s;
  logic                   conv_valid_s;
  logic                   selk_s;
  logic [3*BIT_LEN-1:0]   dato_s;
  logic                   produce_s;

  // A beat may only happen when the result slot is free or being emptied this cycle.
  assign beat_ok_s = !m_valid_q || m_ready;

  // State and counter registers.
  always_ff @(posedge CLK100MHZ or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      col_q     <= COL_ZERO;
      strip_q   <= COL_ZERO;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      strip_q   <= strip_d;
      m_valid_q <= m_valid_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    strip_d = strip_q;
    case (state_q)
      ST_IDLE: begin
        col_d   = COL_ZERO;
        strip_d = COL_ZERO;
        if (i_start) begin
          state_d = i_cmd_kernel ? ST_LOAD_K : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_K: begin
        if (conv_valid_s) begin
          if (col_q == K_LAST) begin
            col_d   = COL_ZERO;
            state_d = ST_RUN;
          end else begin
            col_d = col_q + COL_ONE;
          end
        end else begin
          col_d = col_q;
        end
      end
      ST_RUN: begin
        if (conv_valid_s) begin
          if (col_q == COL_LAST) begin
            col_d   = COL_FLUSH;
            state_d = ST_FLUSH;
          end else begin
            col_d = col_q + COL_ONE;
          end
        end else begin
          col_d = col_q;
        end
      end
      ST_FLUSH: begin
        if (conv_valid_s) begin
          col_d = COL_ZERO;
          if (strip_q == STRIP_LAST) begin
            strip_d = COL_ZERO;
            state_d = ST_DRAIN;
          end else begin
            strip_d = strip_q + COL_ONE;
            state_d = ST_RUN;
          end
        end else begin
          col_d = col_q;
        end
      end
      ST_DRAIN: begin
        if (!m_valid_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        col_d   = COL_ZERO;
        strip_d = COL_ZERO;
      end
    endcase
  end

  // Convolver handshake and upstream ready decode.
  always_comb begin
    s_ready_s    = 1'b0;
    conv_valid_s = 1'b0;
    selk_s       = 1'b1;
    dato_s       = '0;
    case (state_q)
      ST_LOAD_K: begin
        s_ready_s    = beat_ok_s;
        conv_valid_s = s_valid && beat_ok_s;
        selk_s       = 1'b0;
        dato_s       = conv_valid_s ? s_data : '0;
      end
      ST_RUN: begin
        s_ready_s    = beat_ok_s;
        conv_valid_s = s_valid && beat_ok_s;
        dato_s       = conv_valid_s ? s_data : '0;
      end
      ST_FLUSH: begin
        // Zero column pushes the last window of the strip out of the convolver.
        conv_valid_s = beat_ok_s;
      end
      default: begin
        s_ready_s    = 1'b0;
        conv_valid_s = 1'b0;
      end
    endcase
  end

  // Image beats from index 3 on complete a window whose result registers next cycle.
  assign produce_s = conv_valid_s && selk_s && (col_q >= FIRST_PROD);

  always_comb begin
    if (produce_s) begin
      m_valid_d = 1'b1;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

`ifdef CONV_CTRL_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    if ((state_q == ST_IDLE) && i_start) begin
      stall_d = 16'd0;
    end else if (((state_q == ST_RUN) || (state_q == ST_FLUSH)) && !conv_valid_s) begin
      stall_d = sat_inc16(stall_q);
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge CLK100MHZ or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign o_stall_cnt = stall_q;
`endif

  assign s_ready         = s_ready_s;
  assign o_conv_valid    = conv_valid_s;
  assign o_conv_selecK_I = selk_s;
  assign o_conv_dato0    = dato_s[BIT_LEN-1:0];
  assign o_conv_dato1    = dato_s[2*BIT_LEN-1:BIT_LEN];
  assign o_conv_dato2    = dato_s[3*BIT_LEN-1:2*BIT_LEN];
  assign m_data          = i_conv_data;
  assign m_valid         = m_valid_q;
  assign o_busy          = (state_q != ST_IDLE);
  assign o_done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_ctrl.sv
// Randomized bench for conv_ctrl with a mock convolver and a window-sum reference model.
module tb_conv_ctrl;

  localparam int BL = 8;
  localparam int CL = 13;
  localparam int W  = 4;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst_n, start, cmd_k, s_valid, s_ready;
  logic [23:0]   s_data;
  logic [7:0]    d0, d1, d2;
  logic          selk, cvalid, m_valid, m_ready, busy, done;
  logic [CL-1:0] conv_data, m_data;
  logic          pwr;
`ifdef CONV_CTRL_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  conv_ctrl #(.BIT_LEN(BL), .CONV_LPOS(CL), .IMG_W(W), .IMG_STRIPS(S)) dut (
    .CLK100MHZ(clk), .i_reset_n(rst_n), .i_start(start), .i_cmd_kernel(cmd_k),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .o_conv_dato0(d0), .o_conv_dato1(d1), .o_conv_dato2(d2),
    .o_conv_selecK_I(selk), .o_conv_valid(cvalid), .i_conv_data(conv_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .o_busy(busy), .o_done(done)
`ifdef CONV_CTRL_STALL_CNT_EN
    , .o_stall_cnt(stall_cnt)
`endif
  );

  // Mock convolver: kernel and pixel windows as three packed columns, oldest at the bottom.
  logic [71:0] kern, win;

  function automatic logic [CL-1:0] dot(input logic [71:0] k, input logic [71:0] w);
    int acc = 0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        acc += int'(k[24*c+8*r +: 8]) * int'(w[24*c+8*r +: 8]);
    return CL'(acc);
  endfunction

  always @(posedge clk) begin
    if (!pwr) begin
      kern      <= {9{8'h01}};
      win       <= '0;
      conv_data <= '0;
    end else if (cvalid) begin
      if (!selk) kern <= {d2, d1, d0, kern[71:24]};
      else begin
        conv_data <= dot(kern, win);
        win       <= {d2, d1, d0, win[71:24]};
      end
    end
  end

  // Reference model state.
  int img [S][W][3];
  int kk  [3][3];
  int exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_mvalid"}, int'(m_valid), 0);
    check_eq({tag, "_cvalid"}, int'(cvalid), 0);
    check_eq({tag, "_sready"}, int'(s_ready), 0);
    check_eq({tag, "_selk"}, int'(selk), 1);
    check_eq({tag, "_dato"}, int'({d2, d1, d0}), 0);
    check_eq({tag, "_done"}, int'(done), 0);
  endtask

  // mode: 0 plain, 1 random s_valid, 2 m_ready stall, 3 three RUN gaps, 4 reset mid-job
  task automatic run_job(input bit use_k, input logic [71:0] kcols, input int mode);
    logic [23:0]   q[$];
    int            kb = 0, ib = 0, nres = 0, ndone = 0, cyc = 0, hold = 0, pushed = 0;
    bit            finished = 0, stall_started = 0;
    bit            gap_used [8];
    logic [CL-1:0] held = '0;
    for (int i = 0; i < 8; i++) gap_used[i] = 1'b0;

    for (int s = 0; s < S; s++)
      for (int c = 0; c < W; c++)
        for (int r = 0; r < 3; r++)
          img[s][c][r] = int'($urandom_range(255, 0));
    if (use_k) begin
      for (int k = 0; k < 3; k++) begin
        q.push_back(kcols[24*k +: 24]);
        for (int r = 0; r < 3; r++) kk[k][r] = int'(kcols[24*k+8*r +: 8]);
      end
    end
    exp_q.delete();
    for (int s = 0; s < S; s++)
      for (int c = 1; c <= W - 2; c++) begin
        int acc = 0;
        for (int k = 0; k < 3; k++)
          for (int r = 0; r < 3; r++)
            acc += kk[k][r] * img[s][c-1+k][r];
        exp_q.push_back(acc % 8192);
      end
    for (int s = 0; s < S; s++)
      for (int c = 0; c < W; c++)
        q.push_back({img[s][c][2][7:0], img[s][c][1][7:0], img[s][c][0][7:0]});

    start = 1'b1; cmd_k = use_k; s_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!finished && cyc < 400) begin
      if (mode == 4 && ib == 7) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("abort_idle", int'(busy), 0);
        exp_q.delete();
        return;
      end
      if (mode == 2 && !stall_started && m_valid) begin
        stall_started = 1'b1;
        hold = 5;
        held = m_data;
      end
      m_ready = (hold > 0) ? 1'b0 : 1'b1;
      start   = (mode == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
      if (q.size() == 0) s_valid = 1'b0;
      else if (mode == 1) s_valid = 1'($urandom_range(1, 0));
      else if (mode == 3 && (pushed == 1 || pushed == 2 || pushed == 5) && !gap_used[pushed]) begin
        s_valid = 1'b0;
        gap_used[pushed] = 1'b1;
      end else s_valid = 1'b1;
      s_data = (q.size() > 0) ? q[0] : 24'($urandom);
      #1;
      if (hold > 0) begin
        check_eq("stall_cvalid", int'(cvalid), 0);
        check_eq("stall_sready", int'(s_ready), 0);
        check_eq("stall_mdata", int'(m_data), int'(held));
        hold--;
      end
      if (cvalid && !selk) kb++;
      if (cvalid && selk) ib++;
      if (s_valid && s_ready) begin
        if (!selk) void'(q.pop_front());
        else begin
          void'(q.pop_front());
          pushed++;
        end
      end
      if (m_valid && m_ready) begin
        nres++;
        if (exp_q.size() > 0) check_eq("result", int'(m_data), exp_q.pop_front());
      end
      if (done) begin
        ndone++;
        finished = 1'b1;
`ifdef CONV_CTRL_STALL_CNT_EN
        if (mode == 3) check_eq("stall_cnt", int'(stall_cnt), 3);
`endif
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    s_valid = 1'b0;
    #1;
    check_eq("job_timeout", int'(finished), 1);
    check_eq("k_beats", kb, use_k ? 3 : 0);
    check_eq("img_beats", ib, S * (W + 1));
    check_eq("n_results", nres, S * (W - 2));
    check_eq("n_done", ndone, 1);
    check_eq("idle_after", int'(busy), 0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 3; r++)
        kk[k][r] = 1;
    pwr = 1'b0; rst_n = 1'b0; start = 1'b0; cmd_k = 1'b0;
    s_valid = 1'b0; s_data = 24'd0; m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    pwr = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    run_job(1'b0, 72'd0, 0);
    run_job(1'b1, {24'h000000, 24'h000100, 24'h000000}, 0);
    run_job(1'b0, 72'd0, 2);
    run_job(1'b0, 72'd0, 1);
    run_job(1'b0, 72'd0, 4);
    run_job(1'b0, 72'd0, 0);
    run_job(1'b0, 72'd0, 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_ctrl.md
CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 SHALL have parameter BIT_LEN, default 8, pixel/kernel coefficient width.
REQ-002 SHALL have parameter CONV_LPOS, default 13, convolver result width.
REQ-003 SHALL have parameter IMG_W, default 16, image columns per strip; legal range 3..4095.
REQ-004 SHALL have parameter IMG_STRIPS, default 8, strips per job; legal range 1..4095.
REQ-005 SHALL have port CLK100MHZ, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_start, input, 1, job start pulse; sampled only in IDLE.
REQ-008 SHALL have port i_cmd_kernel, input, 1, sampled with i_start; 1 = load 3 kernel columns before the image.
REQ-009 SHALL have ports s_data (input, 3*BIT_LEN), s_valid (input, 1) and s_ready (output, 1), upstream column stream; {row2,row1,row0}.
REQ-010 SHALL have ports o_conv_dato0, o_conv_dato1 and o_conv_dato2 (output, BIT_LEN each), rows 0..2 to the convolver.
REQ-011 SHALL have ports o_conv_selecK_I (output, 1; 0 = kernel, 1 = image) and o_conv_valid (output, 1), convolver controls.
REQ-012 SHALL have port i_conv_data, input, CONV_LPOS, convolver registered result.
REQ-013 SHALL have ports m_data (output, CONV_LPOS), m_valid (output, 1) and m_ready (input, 1), result stream.
REQ-014 SHALL have ports o_busy (output, 1; high when not IDLE) and o_done (output, 1; one-cycle job-end pulse).

Function
REQ-015 SHALL implement FSM IDLE -> LOAD_K (if i_cmd_kernel, else RUN) -> RUN <-> FLUSH -> DRAIN -> DONE -> IDLE.
REQ-016 SHALL define a beat as a cycle with o_conv_valid=1; each beat passes s_data to o_conv_dato* combinationally, with s_valid&&s_ready.
REQ-017 SHALL in LOAD_K drive selecK_I=0 and accept exactly 3 beats, then enter RUN.
REQ-018 SHALL in RUN drive selecK_I=1 and accept IMG_W beats per strip, beat index j=0..IMG_W-1, then enter FLUSH.
REQ-019 SHALL in FLUSH issue one beat with j=IMG_W, dato*=0, s_ready=0, selecK_I=1; then enter RUN (next strip) or DRAIN (last strip).
REQ-020 SHALL allow a beat only when !m_valid || m_ready; s_ready follows that condition in LOAD_K/RUN, else 0.
REQ-021 SHALL set m_valid the cycle after each image beat with j>=3; it clears on m_ready without a new producing beat.
REQ-022 SHALL drive m_data = i_conv_data combinationally; each job yields IMG_STRIPS*(IMG_W-2) results.
REQ-023 SHALL in DRAIN wait for m_valid=0, then enter DONE for one cycle with o_done=1.
REQ-024 SHALL ignore i_start outside IDLE and ignore s_valid in IDLE/FLUSH/DRAIN/DONE.
REQ-025 SHALL handle a producing beat and m_ready in the same cycle by keeping m_valid=1, with no loss or duplicate.
REQ-026 SHALL use column and strip counters that wrap to 0 at the end of each strip and of each job.

Reset
REQ-027 SHALL on i_reset_n=0, at any time, force IDLE, all counters 0, m_valid=0, o_done=0, o_conv_valid=0, s_ready=0, selecK_I=1 and dato*=0.
REQ-028 SHALL, on reset mid-job, discard the job; the kernel already written to the convolver is not restored.

Configuration
REQ-029 SHALL, with CONV_CTRL_STALL_CNT_EN defined, add output o_stall_cnt[15:0]: RUN/FLUSH cycles without a beat, saturating at 0xFFFF, cleared on accepted i_start and on reset.
REQ-030 SHALL, without CONV_CTRL_STALL_CNT_EN, have neither port nor counter; all other behaviour is identical.

Structure
REQ-031 SHALL take the FSM state enum, state width and the beat-index width localparam from the shared package conv_pkg.
REQ-032 SHALL be a single module; the convolver SHALL be instantiated by the parent, not inside conv_ctrl.

Verification
REQ-033 SHALL test: IMG_W=4, IMG_STRIPS=2, i_cmd_kernel=1, kernel 0x000000/0x000100/0x000000, m_ready=1 -> 3 K beats, 10 image beats, 4 results equal to row1 of columns 1,2 per strip, o_done once.
REQ-034 SHALL test: same job with i_cmd_kernel=0 -> no selecK_I=0 beat, 4 results from the default kernel, matching the model.
REQ-035 SHALL test: m_ready held 0 for 5 cycles after first result -> o_conv_valid=0, s_ready=0, m_data stable; resumes with no loss.
REQ-036 SHALL test: s_valid toggled randomly 50% -> result count 4 and values identical to REQ-033.
REQ-037 SHALL test: i_reset_n low during strip 1 col 2 -> next cycle IDLE, m_valid=0; a new job then completes normally.
REQ-038 SHALL test: with CONV_CTRL_STALL_CNT_EN and 3 idle RUN cycles inserted -> o_stall_cnt=3 at o_done.
